// File: rtl/clock_divider_bank_if.sv
// clock_divider_bank_if: divisor-write handshake between a configuring master and clock_divider_bank
//   valid  master->slave  write request
//   ready  slave->master  write can be accepted this cycle
//   ch     master->slave  target channel (CH_W bits)
//   div    master->slave  new divisor (CNT_W bits)
interface clock_divider_bank_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 26
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic             valid;
    logic             ready;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] div;
    modport master (output valid, ch, div, input ready);
    modport slave  (input valid, ch, div, output ready);
endinterface

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: N_CH programmable MCLK dividers producing toggle clocks or one-cycle pulses
//   MCLK      in   system clock, posedge
//   RESET_IN  in   asynchronous active-high reset
//   ch_en     in   per-channel run enable
//   mode      in   per-channel mode, 0 = toggle clock, 1 = pulse
//   cfg       slave modport of clock_divider_bank_if, run-time divisor writes
//   clk_out   out  registered divided clock or pulse
//   tick      out  registered one-cycle pulse on each counter wrap
//   Define CLKGEN_PROG_EN to enable run-time divisor programming; otherwise every
//   divisor stays at DEFAULT_DIV and writes are accepted and ignored.
module clock_divider_bank #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic                 MCLK,
    input  logic                 RESET_IN,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [N_CH-1:0]      mode,
    clock_divider_bank_if.slave  cfg,
    output logic [N_CH-1:0]      clk_out,
    output logic [N_CH-1:0]      tick
);
`ifdef CLKGEN_PROG_EN
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int PW   = 2 ** CH_W;
    logic [N_CH-1:0] pend_v;
    logic [PW-1:0]   pend_x;
    // Padding pend to the full cfg.ch range makes out-of-range channels read as ready.
    assign pend_x    = PW'(pend_v);
    assign cfg.ready = ~pend_x[cfg.ch];
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg.valid, cfg.ch, cfg.div};
    assign cfg.ready  = 1'b1;
`endif
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic             wrap;
        logic             idle;
        logic             clk_r;
        logic             tick_r;
        assign idle       = !ch_en[i] || div == '0;
        assign wrap       = !idle && cnt == div - CNT_W'(1);
        assign clk_out[i] = clk_r;
        assign tick[i]    = tick_r;
        always_ff @(posedge MCLK or posedge RESET_IN) begin
            if (RESET_IN) begin
                cnt    <= '0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                cnt    <= (idle || wrap) ? '0 : cnt + CNT_W'(1);
                tick_r <= wrap;
                clk_r  <= !ch_en[i] ? 1'b0 : div == '0 ? clk_r : mode[i] ? wrap : clk_r ^ wrap;
            end
        end
`ifdef CLKGEN_PROG_EN
        logic [CNT_W-1:0] shad;
        logic             pend;
        logic             take;
        assign pend_v[i] = pend;
        assign take      = cfg.valid && cfg.ready && cfg.ch == CH_W'(i);
        // Applying only at a wrap or while idle keeps cnt at 0 when div changes.
        always_ff @(posedge MCLK or posedge RESET_IN) begin
            if (RESET_IN) begin
                div  <= CNT_W'(DEFAULT_DIV);
                shad <= '0;
                pend <= 1'b0;
            end else if (pend && (wrap || idle)) begin
                div  <= shad;
                pend <= 1'b0;
            end else if (take) begin
                shad <= cfg.div;
                pend <= 1'b1;
            end
        end
`else
        assign div = CNT_W'(DEFAULT_DIV);
`endif
    end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed plus randomized check of clock_divider_bank against a cycle-timestamp reference model
module tb_clock_divider_bank;
    localparam int N = 2, W = 8, DEF = 4;
`ifdef CLKGEN_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif
    logic         MCLK = 1'b0;
    logic         RESET_IN = 1'b1;
    logic [N-1:0] ch_en = '0;
    logic [N-1:0] mode = '0;
    logic [N-1:0] clk_out, tick;
    clock_divider_bank_if #(.N_CH(N), .CNT_W(W)) cfg ();
    clock_divider_bank #(.N_CH(N), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
        .MCLK(MCLK), .RESET_IN(RESET_IN), .ch_en(ch_en), .mode(mode),
        .cfg(cfg), .clk_out(clk_out), .tick(tick)
    );
    always #5 MCLK = ~MCLK;
    int md[N], sh[N], st[N];
    bit pd[N], co[N], tk[N];
    int cyc = 0, vectors = 0, miscompares = 0;
    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            md[c] = DEF; sh[c] = 0; st[c] = cyc; pd[c] = 0; co[c] = 0; tk[c] = 0;
        end
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // One MCLK edge: predict from pre-edge inputs, then compare just after the edge.
    task automatic step();
        bit rdy, w, ap, take;
        logic [N-1:0] eco, etk;
        #1;
        rdy = !PROG || int'(cfg.ch) >= N || !pd[cfg.ch];
        chk("cfg_ready", 8'(cfg.ready), 8'(rdy));
        take = PROG && cfg.valid && rdy && int'(cfg.ch) < N;
        for (int c = 0; c < N; c++) begin
            w = ch_en[c] && md[c] != 0 && (cyc - st[c] + 1) == md[c];
            ap = PROG && pd[c] && (w || !ch_en[c] || md[c] == 0);
            co[c] = !ch_en[c] ? 1'b0 : md[c] == 0 ? co[c] : mode[c] ? w : co[c] ^ w;
            tk[c] = w;
            if (!ch_en[c] || md[c] == 0 || w) st[c] = cyc + 1;
            if (ap) begin
                md[c] = sh[c]; pd[c] = 0;
            end else if (take && int'(cfg.ch) == c) begin
                sh[c] = int'(cfg.div); pd[c] = 1;
            end
            eco[c] = co[c];
            etk[c] = tk[c];
        end
        cyc++;
        @(posedge MCLK);
        #1;
        chk("clk_out", 8'(clk_out), 8'(eco));
        chk("tick", 8'(tick), 8'(etk));
    endtask
    task automatic run(input int n);
        repeat (n) step();
    endtask
    task automatic wr(input int ch, input int d);
        cfg.valid = 1'b1;
        cfg.ch = ch[0];
        cfg.div = W'(d);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        cfg.valid = 1'b0; cfg.ch = '0; cfg.div = '0;
        model_reset();
        repeat (2) @(posedge MCLK);
        #1;
        chk("reset clk_out", 8'(clk_out), 8'h00);
        chk("reset tick", 8'(tick), 8'h00);
        chk("reset ready", 8'(cfg.ready), 8'h01);
        RESET_IN = 1'b0;
        ch_en = 2'b01;
        run(20);
        wr(0, 2); run(1);
        wr(0, 3); run(6);
        cfg.valid = 1'b0; run(12);
        mode = 2'b10;
        wr(1, 3); run(1);
        cfg.valid = 1'b0; run(1);
        ch_en = 2'b11; run(12);
        wr(0, 0); run(1);
        cfg.valid = 1'b0; run(10);
        wr(0, 1); run(1);
        cfg.valid = 1'b0; run(8);
        wr(0, 5); run(1);
        cfg.valid = 1'b0; run(3);
        wr(0, 6); run(1);
        cfg.valid = 1'b0;
        #2 RESET_IN = 1'b1;
        #1;
        chk("async reset clk_out", 8'(clk_out), 8'h00);
        chk("async reset tick", 8'(tick), 8'h00);
        cfg.ch = '0;
        chk("async reset ready", 8'(cfg.ready), 8'h01);
        model_reset();
        #1 RESET_IN = 1'b0;
        mode = 2'b00;
        run(20);
        wr(0, 2); run(1);
        cfg.valid = 1'b0; run(16);
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) ch_en = N'($urandom);
            if ($urandom_range(0, 7) == 0) mode = N'($urandom);
            cfg.valid = 1'($urandom_range(0, 1));
            cfg.ch = 1'($urandom_range(0, N - 1));
            cfg.div = W'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6));
            run(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
